// File: rtl/pacman_input_pkg.sv
// Shared types and constants for the Pacman PS/2 direction decoder.
// Build with PS2_DIR_WASD_EN defined to also map W/A/S/D onto the direction codes.
package pacman_input_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_P     = 8'h4D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_e;

  // One decoded key: the final code byte plus the prefixes that preceded it.
  typedef struct packed {
    logic       valid;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } dir_lookup_t;

  function automatic dir_lookup_t decode_dir(input logic [7:0] code, input logic ext);
    dir_lookup_t r;
    r = '{hit: 1'b0, dir: DIR_LEFT};
    if (ext) begin
      case (code)
        SC_UP:    r = '{hit: 1'b1, dir: DIR_UP};
        SC_DOWN:  r = '{hit: 1'b1, dir: DIR_DOWN};
        SC_LEFT:  r = '{hit: 1'b1, dir: DIR_LEFT};
        SC_RIGHT: r = '{hit: 1'b1, dir: DIR_RIGHT};
        default:  r = '{hit: 1'b0, dir: DIR_LEFT};
      endcase
    end
`ifdef PS2_DIR_WASD_EN
    else begin
      case (code)
        SC_W:    r = '{hit: 1'b1, dir: DIR_UP};
        SC_S:    r = '{hit: 1'b1, dir: DIR_DOWN};
        SC_A:    r = '{hit: 1'b1, dir: DIR_LEFT};
        SC_D:    r = '{hit: 1'b1, dir: DIR_RIGHT};
        default: r = '{hit: 1'b0, dir: DIR_LEFT};
      endcase
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Tracks E0/F0 prefixes with an idle timeout and emits one combinational key
// event per non-prefix byte, tagged with the prefixes seen before it.
module ps2_prefix_fsm
  import pacman_input_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output key_event_t evt
);

  localparam bit               TIMEOUT_EN = (PREFIX_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT      = TIMEOUT_EN ? CNT_W'(PREFIX_TIMEOUT - 1) : '0;

  prefix_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and a latch cannot be inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (ps2_key_pressed) begin
      // A strobe wins over an expiring timeout: the byte sees the current state.
      count_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2_key_data == SC_EXT)      state_d = ST_EXT;
          else if (ps2_key_data == SC_BRK) state_d = ST_BRK;
        end
        ST_EXT: begin
          if (ps2_key_data == SC_BRK)      state_d = ST_EXT_BRK;
          else if (ps2_key_data != SC_EXT) state_d = ST_IDLE;
        end
        ST_BRK: begin
          if (ps2_key_data != SC_BRK)      state_d = ST_IDLE;
        end
        default:                           state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (TIMEOUT_EN && count_q == LIMIT) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    logic consumed;
    consumed = 1'b0;
    case (state_q)
      ST_IDLE, ST_EXT: consumed = (ps2_key_data == SC_EXT) || (ps2_key_data == SC_BRK);
      ST_BRK:          consumed = (ps2_key_data == SC_BRK);
      default:         consumed = 1'b0;
    endcase
    evt       = '0;
    evt.valid = ps2_key_pressed && !consumed;
    evt.code  = ps2_key_data;
    evt.ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    evt.brk   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  end

endmodule

// File: rtl/ps2_dir_decoder.sv
// Maps PS/2 set-2 arrow (and, with PS2_DIR_WASD_EN, WASD) keys onto a latched
// Pacman direction, held-key bitmap and P-key pause toggle; all outputs registered.
module ps2_dir_decoder
  import pacman_input_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       dir_change,
  output logic [3:0] key_down,
  output logic       pause
);

  key_event_t  evt;
  dir_lookup_t lookup;

  logic [1:0] dir_q, dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic       dir_change_q, dir_change_d;
  logic [3:0] key_down_q, key_down_d;
  logic       pause_q, pause_d;

  ps2_prefix_fsm #(
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
  ) u_prefix_fsm (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .evt             (evt)
  );

  assign lookup = decode_dir(evt.code, evt.ext);

  always_comb begin
    dir_d        = dir_q;
    dir_valid_d  = dir_valid_q;
    dir_change_d = 1'b0;
    key_down_d   = key_down_q;
    pause_d      = pause_q;
    if (evt.valid) begin
      if (lookup.hit) begin
        if (evt.brk) begin
          key_down_d[lookup.dir] = 1'b0;
        end else begin
          // A typematic repeat of the current direction does not pulse.
          key_down_d[lookup.dir] = 1'b1;
          dir_change_d           = !dir_valid_q || (lookup.dir != dir_q);
          dir_d                  = lookup.dir;
          dir_valid_d            = 1'b1;
        end
      end else if (!evt.ext && !evt.brk && evt.code == SC_P) begin
        pause_d = !pause_q;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dir_q        <= DIR_LEFT;
      dir_valid_q  <= 1'b0;
      dir_change_q <= 1'b0;
      key_down_q   <= '0;
      pause_q      <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      dir_valid_q  <= dir_valid_d;
      dir_change_q <= dir_change_d;
      key_down_q   <= key_down_d;
      pause_q      <= pause_d;
    end
  end

  assign dir        = dir_q;
  assign dir_valid  = dir_valid_q;
  assign dir_change = dir_change_q;
  assign key_down   = key_down_q;
  assign pause      = pause_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder: a prefix/key model predicts the
// registered outputs for each strobe; a monitor compares them every cycle.
module tb_ps2_dir_decoder;

  localparam int T = 20;

  typedef struct packed {
    logic [1:0] dir;
    logic       valid;
    logic       change;
    logic [3:0] kd;
    logic       pause;
  } snap_t;

  localparam snap_t RESET_SNAP = '{dir: 2'd2, valid: 1'b0, change: 1'b0, kd: 4'b0000, pause: 1'b0};

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_change;
  logic [3:0] key_down;
  logic       pause;

  ps2_dir_decoder #(
    .PREFIX_TIMEOUT (T)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .dir             (dir),
    .dir_valid       (dir_valid),
    .dir_change      (dir_change),
    .key_down        (key_down),
    .pause           (pause)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  snap_t exp_q[$];
  snap_t m = RESET_SNAP;
  bit    m_ext = 1'b0;
  bit    m_brk = 1'b0;
  int    m_last = 0;

  task automatic check(input string name, input snap_t act, input snap_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got dir=%0d valid=%0b change=%0b key_down=%b pause=%0b, want dir=%0d valid=%0b change=%0b key_down=%b pause=%0b",
               name, $time, act.dir, act.valid, act.change, act.kd, act.pause,
               exp.dir, exp.valid, exp.change, exp.kd, exp.pause);
    end
  endtask

  // Direction for a final code byte, or -1 when it is not a direction key.
  function automatic int key_dir(input logic [7:0] b, input bit ext);
    if (ext) begin
      case (b)
        8'h75:   return 0;
        8'h72:   return 1;
        8'h6B:   return 2;
        8'h74:   return 3;
        default: return -1;
      endcase
    end
`ifdef PS2_DIR_WASD_EN
    case (b)
      8'h1D:   return 0;
      8'h1B:   return 1;
      8'h1C:   return 2;
      8'h23:   return 3;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int  d;
    bit  live;
    live = (m_ext || m_brk) && (T == 0 || (cyc - m_last) <= T);
    if (!live) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    m.change = 1'b0;
    if (b == 8'hE0 && !m_brk) begin
      m_ext = 1'b1;
      m_last = cyc;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1'b1;
      m_last = cyc;
    end else if (b == 8'hF0 && m_brk && !m_ext) begin
      m_last = cyc;
    end else begin
      d = key_dir(b, m_ext);
      if (d >= 0) begin
        if (m_brk) begin
          m.kd[d] = 1'b0;
        end else begin
          m.kd[d]  = 1'b1;
          m.change = !m.valid || (m.dir != 2'(d));
          m.dir    = 2'(d);
          m.valid  = 1'b1;
        end
      end else if (!m_ext && !m_brk && b == 8'h4D) begin
        m.pause = ~m.pause;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    exp_q.push_back(m);
  endtask

  task automatic step(input bit s, input logic [7:0] b);
    @(posedge clock);
    #1;
    ps2_key_pressed = s;
    ps2_key_data    = s ? b : 8'($urandom);
    if (s) model_byte(b);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    m               = RESET_SNAP;
    m_ext           = 1'b0;
    m_brk           = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: outputs after a strobe come from the queue, otherwise they hold.
  bit    prev_strobe = 1'b0;
  snap_t held = RESET_SNAP;
  always @(negedge clock) begin
    snap_t act;
    act = '{dir: dir, valid: dir_valid, change: dir_change, kd: key_down, pause: pause};
    if (!resetn) begin
      prev_strobe = 1'b0;
      held        = RESET_SNAP;
      check("reset_values", act, RESET_SNAP);
    end else begin
      if (prev_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow @%0t: no expected entry for a strobe", $time);
        end else begin
          held = exp_q.pop_front();
          check("after_strobe", act, held);
        end
      end else begin
        check("hold", act, held);
      end
      held.change = 1'b0;
      prev_strobe = ps2_key_pressed;
    end
  end

  localparam logic [7:0] PICK [12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                                       8'h4D, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0};

  initial begin
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    idle(2);

    // Up make: one pulse, key_down=0001.
    send(8'hE0); send(8'h75); idle(3);

    // Left make then three typematic repeats: only the first pulses.
    do_reset();
    send(8'hE0); send(8'h6B); idle(1);
    repeat (3) begin send(8'hE0); send(8'h6B); idle(1); end

    // Right make then break: dir holds, key_down clears, no pulse.
    send(8'hE0); send(8'h74); idle(2);
    send(8'hE0); send(8'hF0); send(8'h74); idle(2);

    // Prefix timeout: late byte ignored, byte on the last count still decoded.
    send(8'hE0); idle(T);     send(8'h75); idle(2);
    send(8'hE0); idle(T - 1); send(8'h75); idle(2);

    // Pause toggles on makes only.
    send(8'h4D); idle(1); send(8'hF0); send(8'h4D); idle(1); send(8'h4D); idle(2);

    // Reset mid-prefix discards the sequence.
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h75); idle(3);

    // Randomized traffic including gaps around the timeout boundary.
    for (int i = 0; i < 600; i++) begin
      int g;
      logic [7:0] b;
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else                           b = PICK[$urandom_range(0, 11)];
      send(b);
      case ($urandom_range(0, 15))
        0:       g = T - 1;
        1:       g = T;
        2:       g = T + 1;
        default: g = $urandom_range(0, 2);
      endcase
      idle(g);
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
